// File: rtl/shift_button_conditioner.sv
// Two-button front end for programmable_blinker: synchronise, debounce, press-edge
// detect and auto-repeat each button into one-cycle shift commands, with both-held lockout.
module shift_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic shift_left,
    output logic shift_right,
    output logic left_level,
    output logic right_level
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY == 0) ? 32'd0 : REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
    localparam logic [1:0] ST_REPEAT     = 2'd2;

    // Index 0 is the left button, index 1 the right button throughout.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    stable_q;
    logic [1:0]    stable_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    rise;
    logic [1:0]    fall;
    logic [1:0]    state_q [2];
    logic [1:0]    state_d [2];
    logic [TW-1:0] timer_q [2];
    logic [TW-1:0] timer_d [2];
    logic [1:0]    fire;
    logic [1:0]    lock_q;
    logic [1:0]    lock_d;
    logic [1:0]    pulse_q;
    logic [1:0]    pulse_d;
    logic          lock_now;

    assign raw = {btn_right_raw, btn_left_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        fall     = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i];
                    fall[i]     = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lockout looks at next-cycle levels so press pulses landing together are also masked.
    assign lock_now = stable_d[0] & stable_d[1];

    always_comb begin
        fire    = '0;
        lock_d  = '0;
        pulse_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        fire[i]    = 1'b1;
                        timer_d[i] = '0;
                        if (REPEAT_DELAY != 0) begin
                            state_d[i] = ST_PRESS_WAIT;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (timer_q[i] == DELAY_LAST) begin
                        fire[i]    = 1'b1;
                        timer_d[i] = '0;
                        state_d[i] = ST_REPEAT;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (timer_q[i] == PERIOD_LAST) begin
                        fire[i]    = 1'b1;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    timer_d[i] = '0;
                end
            endcase
            if (fall[i] || lock_now) begin
                state_d[i] = ST_IDLE;
                timer_d[i] = '0;
                fire[i]    = 1'b0;
            end
            // A locked-out button stays mute until its own level drops.
            lock_d[i]  = lock_now | (lock_q[i] & stable_d[i]);
            pulse_d[i] = fire[i] & ~lock_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            lock_q   <= '0;
            pulse_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            lock_q   <= lock_d;
            pulse_q  <= pulse_d;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign shift_left  = pulse_q[0];
    assign shift_right = pulse_q[1];
    assign left_level  = stable_q[0];
    assign right_level = stable_q[1];

endmodule

// File: tb/tb_shift_button_conditioner.sv
// Self-checking bench for shift_button_conditioner: vector table, directed corner
// sequences and randomized hold patterns against a press-time based reference model.
module tb_shift_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bl  = 1'b0;
    logic br  = 1'b0;
    logic shift_left;
    logic shift_right;
    logic left_level;
    logic right_level;

    shift_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left_raw (bl),
        .btn_right_raw(br),
        .shift_left   (shift_left),
        .shift_right  (shift_right),
        .left_level   (left_level),
        .right_level  (right_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: raw sample history, levels, press times, lockout marks.
    int         t;
    bit [D+1:0] h [2];
    bit         m_lvl [2];
    bit         m_act [2];
    bit         m_spoil [2];
    bit         m_pulse [2];
    int         m_press [2];
    int         lp [$];
    int         rp [$];

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            h[b]       = '0;
            m_lvl[b]   = 1'b0;
            m_act[b]   = 1'b0;
            m_spoil[b] = 1'b0;
            m_pulse[b] = 1'b0;
            m_press[b] = 0;
        end
    endfunction

    function automatic void model_edge(input bit l, input bit r);
        bit s [2];
        bit nl [2];
        bit flip;
        bit lock;
        int d;
        s[0] = l;
        s[1] = r;
        for (int b = 0; b < 2; b++) begin
            h[b] = {h[b][D:0], s[b]};
            // Level flips once the D samples seen through the synchroniser all disagree.
            flip = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (h[b][j] == m_lvl[b]) flip = 1'b0;
            nl[b] = flip ? !m_lvl[b] : m_lvl[b];
            if (flip && nl[b]) begin
                m_press[b] = t;
                m_act[b]   = 1'b1;
            end
            if (flip && !nl[b]) begin
                m_act[b]   = 1'b0;
                m_spoil[b] = 1'b0;
            end
        end
        lock = nl[0] && nl[1];
        for (int b = 0; b < 2; b++) begin
            if (lock) m_spoil[b] = 1'b1;
            d = t - m_press[b];
            m_pulse[b] = m_act[b] && nl[b] && !m_spoil[b] &&
                         (d == 0 || d == RD || (d > RD && ((d - RD) % RP) == 0));
            m_lvl[b] = nl[b];
        end
    endfunction

    task automatic step(input bit l, input bit r);
        bl = l;
        br = r;
        @(posedge clk);
        t++;
        if (rst) model_reset();
        else     model_edge(l, r);
        #1;
        check("outputs", {shift_left, shift_right, left_level, right_level},
              {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1]});
        check("exclusive", shift_left & shift_right, 0);
        if (shift_left)  lp.push_back(t);
        if (shift_right) rp.push_back(t);
    endtask

    typedef struct {
        bit       l;
        bit       r;
        bit [3:0] exp;   // {shift_left, shift_right, left_level, right_level}
    } vec_t;

    vec_t tbl [20];
    int   exp_off [6];
    bit   bp [6];
    int   t0;
    int   p;
    int   n;
    int   rem [2];
    bit   val [2];

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b0000},
            '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b1010},
            '{1'b1, 1'b0, 4'b0010}, '{1'b1, 1'b0, 4'b0010}, '{1'b1, 1'b0, 4'b0010},
            '{1'b1, 1'b0, 4'b0010}, '{1'b0, 1'b0, 4'b0010}, '{1'b0, 1'b0, 4'b0010},
            '{1'b0, 1'b0, 4'b0010}, '{1'b0, 1'b0, 4'b0010}, '{1'b0, 1'b0, 4'b0010},
            '{1'b0, 1'b0, 4'b0000}, '{1'b0, 1'b0, 4'b0000}, '{1'b0, 1'b0, 4'b0000},
            '{1'b0, 1'b0, 4'b0000}, '{1'b0, 1'b0, 4'b0000}
        };
        exp_off = '{0, 20, 28, 36, 44, 52};
        bp      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t = 0;
        model_reset();

        // Reset, then reset again with a left press pulse on the outputs.
        repeat (3) step(0, 0);
        rst = 1'b0;
        repeat (6) step(1, 0);
        check("pulse_before_reset", shift_left, 1);
        #2 rst = 1'b1;
        #1 check("reset_async", {shift_left, shift_right, left_level, right_level}, 0);
        repeat (2) step(0, 0);
        rst = 1'b0;
        lp.delete();
        rp.delete();
        repeat (100) step(0, 0);
        check("idle_pulses", lp.size() + rp.size(), 0);

        // Clean left press, held 10 cycles.
        for (int k = 0; k < 20; k++) begin
            step(tbl[k].l, tbl[k].r);
            check($sformatf("table[%0d]", k),
                  {shift_left, shift_right, left_level, right_level}, tbl[k].exp);
        end
        check("table_no_right", rp.size(), 0);
        repeat (10) step(0, 0);

        // Bouncy right press.
        lp.delete();
        rp.delete();
        t0 = t + 1;
        for (int i = 0; i < 6; i++) step(0, bp[i]);
        repeat (14) step(0, 1);
        check("bounce_count", rp.size(), 1);
        check("bounce_edge", (rp.size() > 0) ? rp[0] : 0, t0 + 10);
        repeat (10) step(0, 0);

        // Short glitches on each button.
        lp.delete();
        rp.delete();
        repeat (3) step(0, 1);
        repeat (10) step(0, 0);
        repeat (3) step(1, 0);
        repeat (10) step(0, 0);
        check("glitch_pulses", lp.size() + rp.size(), 0);

        // Auto-repeat on a long left hold.
        lp.delete();
        rp.delete();
        n = 0;
        while (lp.size() == 0 && n < 20) begin
            step(1, 0);
            n++;
        end
        check("repeat_press_seen", lp.size(), 1);
        p = (lp.size() > 0) ? lp[0] : t;
        while (t + 1 <= p + 53) step(1, 0);
        repeat (30) step(0, 0);
        check("repeat_count", lp.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("repeat_pulse[%0d]", i), (i < lp.size()) ? lp[i] - p : -1, exp_off[i]);
        check("repeat_no_right", rp.size(), 0);

        // Both pressed together, then right released, then left re-pressed.
        lp.delete();
        rp.delete();
        repeat (20) step(1, 1);
        check("simul_both", lp.size() + rp.size(), 0);
        repeat (20) step(1, 0);
        check("simul_right_release", lp.size() + rp.size(), 0);
        repeat (10) step(0, 0);
        t0 = t + 1;
        repeat (12) step(1, 0);
        check("simul_repress_count", lp.size(), 1);
        check("simul_repress_edge", (lp.size() > 0) ? lp[0] : 0, t0 + 5);
        repeat (10) step(0, 0);

        // Right held, left joins before right's first repeat.
        lp.delete();
        rp.delete();
        n = 0;
        while (rp.size() == 0 && n < 20) begin
            step(0, 1);
            n++;
        end
        check("hto_press_seen", rp.size(), 1);
        p = (rp.size() > 0) ? rp[0] : t;
        while (t + 1 < p + 10) step(0, 1);
        while (t + 1 <= p + 40) step(1, 1);
        repeat (15) step(0, 0);
        check("hto_left", lp.size(), 0);
        check("hto_right", rp.size(), 1);

        // Randomized hold patterns.
        rem[0] = 0;
        rem[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    val[b] = 1'($urandom_range(0, 1));
                    rem[b] = int'($urandom_range(1, 40));
                end
                rem[b]--;
            end
            step(val[0], val[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
